kanagawa_fifo_write_arbiter: RTL and testbench

// Shares the write port of one show-ahead FIFO (same clock as the write side) between NUM_REQ producers.

---
 rtl/kanagawa_fifo_write_arbiter.sv | 120 ++++++++++++
 tb/tb_kanagawa_fifo_write_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NUM_REQ producers.
// Write strobe and data are registered; almost_full throttles, full drops the beat and flags overflow.
module kanagawa_fifo_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 64,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wrreq,
  output logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_almost_full,
  input  logic                     fifo_full,
  output logic [ID_WIDTH-1:0]      grant_id,
  output logic                     busy,
  output logic                     overflow_err
);

  // Handshake: a beat from requester i transfers on a rising clk edge where
  // req_valid[i] & req_ready[i]; only the lock owner ever sees ready.
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic                wr_q, wr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                ovf_q, ovf_d;

  logic [ID_WIDTH-1:0] winner;
  logic                any_valid;
  logic                owner_valid;
  logic                owner_last;
  logic [WIDTH-1:0]    owner_data;
  logic                accept;
  int                  idx;

  // Descending scan so the lowest offset from rr_ptr is the final assignment.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        winner    = ID_WIDTH'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign owner_valid = req_valid[grant_q];
  assign owner_last  = req_last[grant_q];
  assign owner_data  = req_data[int'(grant_q)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == ST_LOCKED) && !fifo_almost_full) req_ready[grant_q] = 1'b1;
  end

  assign accept = (state_q == ST_LOCKED) && owner_valid && !fifo_almost_full && !rst;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wr_d     = accept;
    data_d   = data_q;
    ovf_d    = ovf_q | (wr_q & fifo_full);
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_LOCKED;
          grant_d = winner;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          data_d = owner_data;
          if (owner_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // A pending write that meets fifo_full is dropped rather than overrunning the FIFO.
  assign fifo_wrreq   = wr_q & ~fifo_full;
  assign fifo_data    = data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q == ST_LOCKED);
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_kanagawa_fifo_write_arbiter.sv
// Directed bench for kanagawa_fifo_write_arbiter: per-requester beat generators,
// a write monitor feeding an expected-data scoreboard, and cycle-level checks.
module tb_kanagawa_fifo_write_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wrreq;
  logic [W-1:0]   fifo_data;
  logic           fifo_almost_full;
  logic           fifo_full;
  logic [1:0]     grant_id;
  logic           busy;
  logic           overflow_err;

  kanagawa_fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy), .overflow_err(overflow_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_extra  = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           wc_q[$];

  int left[N];
  int len[N];
  int bn[N];
  int base[N];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pl(input int i, input int v);
    return {32'(i), 32'(v)};
  endfunction

  // scoreboard: every observed write must match the head of exp_q
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wrreq === 1'b1) begin
      wc_q.push_back(cyc);
      if (exp_q.size() == 0) n_extra++;
      else check("sb_data", fifo_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = (left[i] > 0);
      req_data[i*W +: W]  = pl(i, base[i] + bn[i]);
      req_last[i]         = (len[i] > 0) && ((bn[i] % len[i]) == len[i] - 1);
    end
  endtask

  task automatic load(input int i, input int n, input int l, input int b);
    left[i] = n;
    len[i]  = l;
    bn[i]   = 0;
    base[i] = b;
    drive();
  endtask

  // Ends at posedge+1 with handshakes of the previous edge applied.
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        bn[i]++;
        left[i]--;
      end
    end
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic step_until(input string tag, input int i, input int target, input int budget);
    int k = 0;
    while (bn[i] < target && k < budget) begin
      step();
      k++;
    end
    check(tag, bn[i], target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      left[i] = 0; len[i] = 1; bn[i] = 0; base[i] = 0;
    end
    rst = 1'b1;
    fifo_almost_full = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;

    // Reset held 3 cycles with all requesters valid (1-beat packets, req0 sends two)
    load(0, 2, 1, 0);
    load(1, 1, 1, 0);
    load(2, 1, 1, 0);
    load(3, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_wrreq", fifo_wrreq, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_grant", grant_id, 0);
    check("rst_data", fifo_data, 0);
    check("rst_ovf", overflow_err, 0);

    // Round-robin over single-beat packets
    exp_q.push_back(pl(0, 0));
    exp_q.push_back(pl(1, 0));
    exp_q.push_back(pl(2, 0));
    exp_q.push_back(pl(3, 0));
    exp_q.push_back(pl(0, 1));
    wc_q.delete();
    rst = 1'b0;
    step();
    #1;
    check("rr_first_busy", busy, 1);
    check("rr_first_grant", grant_id, 0);
    drain("rr_drain", 40);
    check("rr_nwrites", wc_q.size(), 5);
    if (wc_q.size() == 5)
      for (int k = 0; k < 4; k++) check("rr_spacing", wc_q[k+1] - wc_q[k], 2);

    // Packet lock: req1 3 beats while others wait; next search starts at 2
    wc_q.delete();
    load(1, 3, 3, 100);
    load(0, 1, 1, 100);
    load(2, 1, 1, 100);
    load(3, 1, 1, 100);
    exp_q.push_back(pl(1, 100));
    exp_q.push_back(pl(1, 101));
    exp_q.push_back(pl(1, 102));
    exp_q.push_back(pl(2, 100));
    exp_q.push_back(pl(3, 100));
    exp_q.push_back(pl(0, 100));
    drain("lock_drain", 60);
    check("lock_nwrites", wc_q.size(), 6);
    if (wc_q.size() == 6) begin
      check("lock_contig0", wc_q[1] - wc_q[0], 1);
      check("lock_contig1", wc_q[2] - wc_q[1], 1);
    end

    // Backpressure on beat 2 of a 4-beat req1 packet
    load(1, 4, 4, 200);
    for (int k = 0; k < 4; k++) exp_q.push_back(pl(1, 200 + k));
    step_until("bp_reach", 1, 2, 20);
    fifo_almost_full = 1'b1;
    #1;
    check("bp_ready_drop", req_ready, 0);
    check("bp_prev_write", fifo_wrreq, 1);
    step();
    #1;
    check("bp_stall_wr0", fifo_wrreq, 0);
    step();
    #1;
    check("bp_stall_wr1", fifo_wrreq, 0);
    check("bp_bn_held", bn[1], 2);
    fifo_almost_full = 1'b0;
    drain("bp_drain", 30);

    // Overflow: full while a write is pending drops it and sets the sticky flag
    load(2, 1, 1, 300);
    step_until("ovf_reach", 2, 1, 20);
    fifo_full = 1'b1;
    #1;
    check("ovf_wrreq_gated", fifo_wrreq, 0);
    step();
    #1;
    check("ovf_set", overflow_err, 1);
    fifo_full = 1'b0;
    load(3, 1, 1, 301);
    exp_q.push_back(pl(3, 301));
    drain("ovf_drain", 30);
    for (int c = 0; c < 3; c++) step();
    #1;
    check("ovf_sticky", overflow_err, 1);

    // Reset mid-packet: req2 loses the rest of its packet, next grant is req0
    load(2, 4, 4, 400);
    step_until("mid_reach", 2, 1, 20);
    exp_q.push_back(pl(2, 400));
    rst = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 0);
    step();
    rst = 1'b0;
    left[2] = 0;
    drive();
    #1;
    check("mid_ovf_clr", overflow_err, 0);
    check("mid_wrreq", fifo_wrreq, 0);
    check("mid_busy", busy, 0);
    load(0, 1, 1, 500);
    load(2, 1, 1, 501);
    exp_q.push_back(pl(0, 500));
    exp_q.push_back(pl(2, 501));
    step();
    #1;
    check("mid_next_busy", busy, 1);
    check("mid_next_grant", grant_id, 0);
    drain("mid_drain", 30);

    for (int c = 0; c < 6; c++) step();
    check("sb_extra_writes", n_extra, 0);
    check("sb_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
